// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined carry-lookahead adder.
//   GRP_W       - bits per lookahead group
//   num_groups  - number of 4-bit groups for a given operand width
//   OP_ADD/SUB  - encoding of the i_sub operation select
package cla_pkg;

    localparam int unsigned GRP_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int unsigned num_groups(input int unsigned width);
        return width / GRP_W;
    endfunction

endpackage

// File: rtl/cla_group_gp.sv
// cla_group_gp: combinational 4-bit carry-lookahead group.
//   i_g, i_p - per-bit generate / propagate of the group
//   i_c      - carry into bit 0 of the group
//   o_gg     - group generate G*
//   o_pg     - group propagate P*
//   o_c      - in-group carries c1..c3 (o_c[0] is c1)
module cla_group_gp (
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_c,
    output logic       o_gg,
    output logic       o_pg,
    output logic [2:0] o_c
);

    assign o_gg = i_g[3]
                | (i_p[3] & i_g[2])
                | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);

    assign o_pg = &i_p;

    assign o_c[0] = i_g[0] | (i_p[0] & i_c);
    assign o_c[1] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
    assign o_c[2] = i_g[2]
                  | (i_p[2] & i_g[1])
                  | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_c);

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: two-stage pipelined adder/subtractor using two-level carry lookahead.
//   i_clk, i_rst_n           - clock, asynchronous active-low reset
//   i_in_valid / o_in_ready  - operand handshake (i_a, i_b, i_cin, i_sub)
//   i_sub                    - 0: a + b + cin, 1: a - b (cin ignored)
//   o_out_valid / i_out_ready- result handshake (o_sum, o_cout, o_ovf, o_zero)
//   o_cout                   - carry out; for subtraction 1 means no borrow
//   o_ovf                    - two's-complement signed overflow
//   o_zero                   - o_sum == 0
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int unsigned NG    = num_groups(WIDTH);
    localparam int          SET_G = 4;  // groups resolved together before rippling

    if ((WIDTH % GRP_W) != 0 || WIDTH < GRP_W) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    // Flow control
    logic w_s2_adv, w_s1_adv, w_accept;
    logic r_s1_valid, r_s2_valid;

    assign w_s2_adv    = ~r_s2_valid | i_out_ready;
    assign w_s1_adv    = r_s1_valid & w_s2_adv;
    // Combinational from i_out_ready so a full pipeline can still accept while draining.
    assign o_in_ready  = ~r_s1_valid | w_s2_adv;
    assign w_accept    = i_in_valid & o_in_ready;
    assign o_out_valid = r_s2_valid;

    // Stage 1: per-bit and per-group generate/propagate
    logic [WIDTH-1:0] w_bm, w_g, w_p;
    logic             w_c0;
    logic [NG-1:0]    w_gg, w_pg;
    logic [3*NG-1:0]  w_unused_s1_c;

    assign w_bm = (i_sub == OP_SUB) ? ~i_b : i_b;
    assign w_c0 = (i_sub == OP_SUB) ? 1'b1 : i_cin;
    assign w_g  = i_a & w_bm;
    assign w_p  = i_a ^ w_bm;

    for (genvar k = 0; k < NG; k++) begin : g_s1_grp
        cla_group_gp u_gp (
            .i_g  (w_g[GRP_W*k +: GRP_W]),
            .i_p  (w_p[GRP_W*k +: GRP_W]),
            .i_c  (1'b0),
            .o_gg (w_gg[k]),
            .o_pg (w_pg[k]),
            .o_c  (w_unused_s1_c[3*k +: 3])
        );
    end

    logic [WIDTH-1:0] r_g, r_p;
    logic [NG-1:0]    r_gg, r_pg;
    logic             r_c0, r_a_msb, r_bm_msb;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_g        <= '0;
            r_p        <= '0;
            r_gg       <= '0;
            r_pg       <= '0;
            r_c0       <= 1'b0;
            r_a_msb    <= 1'b0;
            r_bm_msb   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_g        <= w_g;
                r_p        <= w_p;
                r_gg       <= w_gg;
                r_pg       <= w_pg;
                r_c0       <= w_c0;
                r_a_msb    <= i_a[WIDTH-1];
                r_bm_msb   <= w_bm[WIDTH-1];
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: group carries, lookahead within sets of 4 groups, ripple between sets
    logic [NG:0] w_cg;

    always_comb begin
        logic [NG:0] v_cg;
        logic        v_t, v_p;
        int          base;
        v_cg    = '0;
        v_cg[0] = r_c0;
        for (int k = 0; k < int'(NG); k++) begin
            base = (k / SET_G) * SET_G;
            v_t  = r_gg[k];
            v_p  = r_pg[k];
            for (int m = k - 1; m >= base; m--) begin
                v_t = v_t | (v_p & r_gg[m]);
                v_p = v_p & r_pg[m];
            end
            v_cg[k+1] = v_t | (v_p & v_cg[base]);
        end
        w_cg = v_cg;
    end

    logic [WIDTH-1:0] w_c, w_sum;
    logic [NG-1:0]    w_unused_s2_gg, w_unused_s2_pg;

    for (genvar k = 0; k < NG; k++) begin : g_s2_grp
        assign w_c[GRP_W*k] = w_cg[k];
        cla_group_gp u_gp (
            .i_g  (r_g[GRP_W*k +: GRP_W]),
            .i_p  (r_p[GRP_W*k +: GRP_W]),
            .i_c  (w_cg[k]),
            .o_gg (w_unused_s2_gg[k]),
            .o_pg (w_unused_s2_pg[k]),
            .o_c  (w_c[GRP_W*k+1 +: 3])
        );
    end

    assign w_sum = r_p ^ w_c;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout, r_ovf, r_zero;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_sum      <= w_sum;
                r_cout     <= w_cg[NG];
                r_ovf      <= (r_a_msb == r_bm_msb) & (w_sum[WIDTH-1] != r_a_msb);
                r_zero     <= ~|w_sum;
            end else if (w_s2_adv) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;
    assign o_zero = r_zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
`timescale 1ns/1ps
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready, cin, sub;
    logic [31:0] a32, b32;

    always #5 clk = ~clk;

    logic        in_ready16, out_valid16, cout16, ovf16, zero16;
    logic [15:0] sum16;
    logic        in_ready32, out_valid32, cout32, ovf32, zero32;
    logic [31:0] sum32;
    logic        in_ready4, out_valid4, cout4, ovf4, zero4;
    logic [3:0]  sum4;

    pipelined_cla_adder #(.WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready16),
        .i_a(a32[15:0]), .i_b(b32[15:0]), .i_cin(cin), .i_sub(sub),
        .o_out_valid(out_valid16), .i_out_ready(out_ready),
        .o_sum(sum16), .o_cout(cout16), .o_ovf(ovf16), .o_zero(zero16)
    );

    pipelined_cla_adder #(.WIDTH(32)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready32),
        .i_a(a32), .i_b(b32), .i_cin(cin), .i_sub(sub),
        .o_out_valid(out_valid32), .i_out_ready(out_ready),
        .o_sum(sum32), .o_cout(cout32), .o_ovf(ovf32), .o_zero(zero32)
    );

    pipelined_cla_adder #(.WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready4),
        .i_a(a32[3:0]), .i_b(b32[3:0]), .i_cin(cin), .i_sub(sub),
        .o_out_valid(out_valid4), .i_out_ready(out_ready),
        .o_sum(sum4), .o_cout(cout4), .o_ovf(ovf4), .o_zero(zero4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic s);
        longint unsigned m, ua, ub, full;
        longint          sa, sb, sr, lim;
        res_t            r;
        m   = (64'd1 << w) - 1;
        ua  = {32'd0, a} & m;
        ub  = {32'd0, b} & m;
        lim = longint'(64'd1 << (w - 1));
        if (s) full = ua + (64'd1 << w) - ub;
        else   full = ua + ub + (ci ? 64'd1 : 64'd0);
        sa = longint'(ua);
        sb = longint'(ub);
        if (sa >= lim) sa = sa - 2 * lim;
        if (sb >= lim) sb = sb - 2 * lim;
        sr = s ? (sa - sb) : (sa + sb + (ci ? 1 : 0));
        r.sum  = 32'(full & m);
        r.cout = ((full >> w) & 64'd1) != 0;
        r.ovf  = (sr < -lim) || (sr > lim - 1);
        r.zero = (full & m) == 0;
        return r;
    endfunction

    // Scoreboards for the random phase
    logic mon_en = 1'b0;
    res_t q16[$], q32[$], q4[$];
    int   acc16 = 0, acc32 = 0, acc4 = 0;
    int   out16 = 0, out32 = 0, out4 = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            res_t e;
            if (in_valid && in_ready16) begin q16.push_back(model(16, a32, b32, cin, sub)); acc16++; end
            if (in_valid && in_ready32) begin q32.push_back(model(32, a32, b32, cin, sub)); acc32++; end
            if (in_valid && in_ready4)  begin q4.push_back(model(4, a32, b32, cin, sub));   acc4++;  end
            if (out_valid16 && out_ready) begin
                out16++;
                if (q16.size() == 0) check("rand16 unexpected result", 64'd1, 64'd0);
                else begin
                    e = q16.pop_front();
                    check("rand16 result", {29'd0, res_t'({16'd0, sum16, cout16, ovf16, zero16})},
                          {29'd0, e});
                end
            end
            if (out_valid32 && out_ready) begin
                out32++;
                if (q32.size() == 0) check("rand32 unexpected result", 64'd1, 64'd0);
                else begin
                    e = q32.pop_front();
                    check("rand32 result", {29'd0, res_t'({sum32, cout32, ovf32, zero32})},
                          {29'd0, e});
                end
            end
            if (out_valid4 && out_ready) begin
                out4++;
                if (q4.size() == 0) check("rand4 unexpected result", 64'd1, 64'd0);
                else begin
                    e = q4.pop_front();
                    check("rand4 result", {29'd0, res_t'({28'd0, sum4, cout4, ovf4, zero4})},
                          {29'd0, e});
                end
            end
        end
    end

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] sum;
        logic        cout, ovf, zero;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{16'h5555, 16'h5555, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a32 = '0; b32 = '0; cin = 1'b0; sub = 1'b0;
        #2;
        check("reset out_valid", {63'd0, out_valid16}, 64'd0);
        check("reset sum/flags", {45'd0, sum16, cout16, ovf16, zero16}, 64'd0);
        check("reset out_valid w32/w4", {62'd0, out_valid32, out_valid4}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("idle in_ready", {63'd0, in_ready16}, 64'd1);

        // Directed vectors on WIDTH=16, one op at a time
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a32 = {16'd0, vecs[i].a}; b32 = {16'd0, vecs[i].b};
            cin = vecs[i].cin; sub = vecs[i].sub; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d not yet valid", i), {63'd0, out_valid16}, 64'd0);
            tick();
            check($sformatf("vec%0d out_valid", i), {63'd0, out_valid16}, 64'd1);
            check($sformatf("vec%0d sum", i), {48'd0, sum16}, {48'd0, vecs[i].sum});
            check($sformatf("vec%0d cout/ovf/zero", i), {61'd0, cout16, ovf16, zero16},
                  {61'd0, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
        end
        tick();

        // Back-pressure: 1+1, 2+2, 3+3 with consumer stalled
        out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
        a32 = 32'd1; b32 = 32'd1; in_valid = 1'b1;
        check("bp ready op1", {63'd0, in_ready16}, 64'd1);
        tick();
        a32 = 32'd2; b32 = 32'd2;
        check("bp ready op2", {63'd0, in_ready16}, 64'd1);
        tick();
        a32 = 32'd3; b32 = 32'd3;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp stall%0d in_ready", i), {63'd0, in_ready16}, 64'd0);
            check($sformatf("bp stall%0d hold", i), {46'd0, out_valid16, sum16, cout16},
                  {46'd0, 1'b1, 16'h0002, 1'b0});
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", {63'd0, in_ready16}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp out2", {47'd0, out_valid16, sum16}, {47'd0, 1'b1, 16'h0004});
        tick();
        check("bp out3", {47'd0, out_valid16, sum16}, {47'd0, 1'b1, 16'h0006});
        tick();
        check("bp drained", {63'd0, out_valid16}, 64'd0);

        // Asynchronous reset with two operations in flight
        out_ready = 1'b0;
        a32 = 32'h7FFF; b32 = 32'h0001; in_valid = 1'b1;
        tick();
        a32 = 32'h0001; b32 = 32'h0001;
        tick();
        in_valid = 1'b0;
        check("rst pre out", {46'd0, out_valid16, sum16, ovf16}, {46'd0, 1'b1, 16'h8000, 1'b1});
        #3 rst_n = 1'b0;
        #1;
        check("rst async out_valid", {63'd0, out_valid16}, 64'd0);
        check("rst async sum/flags", {45'd0, sum16, cout16, ovf16, zero16}, 64'd0);
        check("rst async in_ready", {63'd0, in_ready16}, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rst no stale %0d", i), {61'd0, out_valid16, out_valid32, out_valid4},
                  64'd0);
        end

        // Random phase on all three widths
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 5000 && acc16 < 1000; cyc++) begin
            a32 = $urandom; b32 = $urandom;
            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            in_valid = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            tick();
        end
        check("rand accept budget", {63'd0, acc16 >= 1000}, 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        mon_en = 1'b0;
        check("rand16 count", 64'(out16), 64'(acc16));
        check("rand32 count", 64'(out32), 64'(acc32));
        check("rand4 count", 64'(out4), 64'(acc4));
        check("rand queues empty", 64'(q16.size() + q32.size() + q4.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
